// File: rtl/game_state_regfile_pkg.sv
// Shared types and default register map for the lightbike register file.
// Orientation is two bits: 0 up, 1 right, 2 down, 3 left.
package game_regfile_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } orient_e;

  localparam int DEF_NUM_BIKES = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_NUM_REGS  = 32;
  localparam int DEF_BIKE_BASE = 16;
  localparam int DEF_PWR_BASE  = 24;
  localparam int DEF_FRAME_REG = 28;
  localparam int DEF_SPEED_REG = 29;

  // Opposite direction: flipping bit 1 maps up<->down and right<->left.
  function automatic orient_e reverse_dir(input orient_e d);
    return orient_e'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/game_state_regfile_bike_slot.sv
// Per-bike orientation and powerup timer registers with hardware/CPU priority.
// Exposes both the registered value and the next-state value for read forwarding.
module bike_slot
  import game_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_master,
  input  logic              i_frame_tick,
  input  logic              i_orient_valid,
  input  logic [1:0]        i_orient_in,
  input  logic              i_pwr_set,
  input  logic [DATA_W-1:0] i_pwr_data,
  input  logic              i_cpu_orient_we,
  input  logic              i_cpu_pwr_we,
  input  logic [DATA_W-1:0] i_cpu_data,
  output logic [DATA_W-1:0] o_orient,
  output logic [DATA_W-1:0] o_pwr,
  output logic [DATA_W-1:0] o_orient_nxt,
  output logic [DATA_W-1:0] o_pwr_nxt
);

  logic [DATA_W-1:0] r_orient;
  logic [DATA_W-1:0] r_pwr;
  logic              w_turn_ok;

  // A turn into the opposite of the current heading is dropped.
  assign w_turn_ok = i_orient_valid && i_master &&
                     (orient_e'(i_orient_in) != reverse_dir(orient_e'(r_orient[1:0])));

  always_comb begin
    o_orient_nxt = r_orient;
    o_pwr_nxt    = r_pwr;
    if (!reset) begin
      o_orient_nxt = '0;
      o_pwr_nxt    = '0;
    end else begin
      if (w_turn_ok)
        o_orient_nxt = {{(DATA_W-2){1'b0}}, i_orient_in};
      else if (i_cpu_orient_we)
        o_orient_nxt = i_cpu_data;

      if (i_pwr_set)
        o_pwr_nxt = i_pwr_data;
      else if (i_cpu_pwr_we)
        o_pwr_nxt = i_cpu_data;
      else if (i_frame_tick && i_master && (r_pwr != '0))
        o_pwr_nxt = r_pwr - DATA_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_orient <= '0;
      r_pwr    <= '0;
    end else begin
      r_orient <= o_orient_nxt;
      r_pwr    <= o_pwr_nxt;
    end
  end

  assign o_orient = r_orient;
  assign o_pwr    = r_pwr;

endmodule

// File: rtl/game_state_regfile.sv
// Lightbike game-state register file: 2 forwarding read ports, 1 CPU write port, r0 = 0.
// Bike orientation/powerup registers live in bike_slot; everything else is a plain register.
module game_state_regfile
  import game_regfile_pkg::*;
#(
  parameter int NUM_BIKES = DEF_NUM_BIKES,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int ADDR_W    = $clog2(NUM_REGS),
  parameter int BIKE_BASE = DEF_BIKE_BASE,
  parameter int PWR_BASE  = DEF_PWR_BASE,
  parameter int FRAME_REG = DEF_FRAME_REG,
  parameter int SPEED_REG = DEF_SPEED_REG
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ren_in,
  input  logic [ADDR_W-1:0]           rd_in,
  input  logic [DATA_W-1:0]           data_write,
  input  logic [ADDR_W-1:0]           readA,
  input  logic [ADDR_W-1:0]           readB,
  output logic [DATA_W-1:0]           A,
  output logic [DATA_W-1:0]           B,
  input  logic                        masterSwitch,
  input  logic                        frame_tick,
  input  logic [NUM_BIKES-1:0]        orient_valid,
  input  logic [2*NUM_BIKES-1:0]      orient_in,
  input  logic [NUM_BIKES-1:0]        pwr_set,
  input  logic [DATA_W*NUM_BIKES-1:0] pwr_set_data,
  output logic [DATA_W*NUM_BIKES-1:0] bike_pos,
  output logic [DATA_W*NUM_BIKES-1:0] bike_orient,
  output logic [DATA_W*NUM_BIKES-1:0] bike_pwr,
  output logic [DATA_W-1:0]           frame_count,
  output logic [DATA_W-1:0]           speed_out
);

  if (NUM_BIKES < 1 || NUM_BIKES > 8) begin : g_err_bikes
    $error("NUM_BIKES must be 1..8");
  end
  if (BIKE_BASE + 2*NUM_BIKES > PWR_BASE) begin : g_err_bike_map
    $error("bike registers overlap powerup timers");
  end
  if (PWR_BASE + NUM_BIKES > FRAME_REG) begin : g_err_pwr_map
    $error("powerup timers overlap frame counter");
  end
  if (SPEED_REG >= NUM_REGS) begin : g_err_speed_map
    $error("speed register outside register file");
  end

  logic [DATA_W-1:0] w_cur        [NUM_REGS];
  logic [DATA_W-1:0] w_nxt        [NUM_REGS];
  logic [DATA_W-1:0] w_orient_cur [NUM_BIKES];
  logic [DATA_W-1:0] w_orient_nxt [NUM_BIKES];
  logic [DATA_W-1:0] w_pwr_cur    [NUM_BIKES];
  logic [DATA_W-1:0] w_pwr_nxt    [NUM_BIKES];

  for (genvar i = 0; i < NUM_BIKES; i++) begin : g_bike
    localparam logic [ADDR_W-1:0] ORIENT_IDX = ADDR_W'(BIKE_BASE + 2*i + 1);
    localparam logic [ADDR_W-1:0] PWR_IDX    = ADDR_W'(PWR_BASE + i);

    bike_slot #(.DATA_W(DATA_W)) u_slot (
      .clock          (clock),
      .reset          (reset),
      .i_master       (masterSwitch),
      .i_frame_tick   (frame_tick),
      .i_orient_valid (orient_valid[i]),
      .i_orient_in    (orient_in[2*i +: 2]),
      .i_pwr_set      (pwr_set[i]),
      .i_pwr_data     (pwr_set_data[i*DATA_W +: DATA_W]),
      .i_cpu_orient_we(ren_in && (rd_in == ORIENT_IDX)),
      .i_cpu_pwr_we   (ren_in && (rd_in == PWR_IDX)),
      .i_cpu_data     (data_write),
      .o_orient       (w_orient_cur[i]),
      .o_pwr          (w_pwr_cur[i]),
      .o_orient_nxt   (w_orient_nxt[i]),
      .o_pwr_nxt      (w_pwr_nxt[i])
    );

    assign bike_pos[i*DATA_W +: DATA_W]    = w_cur[BIKE_BASE + 2*i];
    assign bike_orient[i*DATA_W +: DATA_W] = w_orient_cur[i];
    assign bike_pwr[i*DATA_W +: DATA_W]    = w_pwr_cur[i];
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    localparam bit IS_ORIENT = (k >= BIKE_BASE) && (k < BIKE_BASE + 2*NUM_BIKES) &&
                               (((k - BIKE_BASE) % 2) == 1);
    localparam bit IS_PWR    = (k >= PWR_BASE) && (k < PWR_BASE + NUM_BIKES);
    localparam bit IS_FRAME  = (k == FRAME_REG);

    if (k == 0) begin : g_zero
      assign w_cur[k] = '0;
      assign w_nxt[k] = '0;
    end else if (IS_ORIENT) begin : g_orient
      assign w_cur[k] = w_orient_cur[(k - BIKE_BASE) / 2];
      assign w_nxt[k] = w_orient_nxt[(k - BIKE_BASE) / 2];
    end else if (IS_PWR) begin : g_pwr
      assign w_cur[k] = w_pwr_cur[k - PWR_BASE];
      assign w_nxt[k] = w_pwr_nxt[k - PWR_BASE];
    end else begin : g_plain
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(k);
      logic [DATA_W-1:0] r_q;
      logic [DATA_W-1:0] w_d;

      // Frame counter advances on ticks only while the game runs; CPU write wins.
      always_comb begin
        w_d = r_q;
        if (!reset)
          w_d = '0;
        else if (ren_in && (rd_in == IDX))
          w_d = data_write;
        else if (IS_FRAME && frame_tick && masterSwitch)
          w_d = r_q + DATA_W'(1);
      end

      always_ff @(posedge clock) begin
        if (!reset) r_q <= '0;
        else        r_q <= w_d;
      end

      assign w_cur[k] = r_q;
      assign w_nxt[k] = w_d;
    end
  end

  assign A = (readA == '0) ? '0 : w_nxt[readA];
  assign B = (readB == '0) ? '0 : w_nxt[readB];

  assign frame_count = w_cur[FRAME_REG];
  assign speed_out   = w_cur[SPEED_REG];

endmodule

// File: tb/tb_game_state_regfile.sv
// Self-checking bench for game_state_regfile: directed scenarios then random traffic,
// all compared against a register-map reference model built from the game rules.
module tb_game_state_regfile;

  localparam int NB = 4;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int BB = 16;
  localparam int PB = 24;
  localparam int FR = 28;
  localparam int SR = 29;

  logic              clock = 1'b0;
  logic              reset;
  logic              ren_in;
  logic [AW-1:0]     rd_in;
  logic [DW-1:0]     data_write;
  logic [AW-1:0]     readA, readB;
  logic [DW-1:0]     A, B;
  logic              masterSwitch;
  logic              frame_tick;
  logic [NB-1:0]     orient_valid;
  logic [2*NB-1:0]   orient_in;
  logic [NB-1:0]     pwr_set;
  logic [DW*NB-1:0]  pwr_set_data;
  logic [DW*NB-1:0]  bike_pos, bike_orient, bike_pwr;
  logic [DW-1:0]     frame_count, speed_out;

  always #5 clock = ~clock;

  game_state_regfile dut (
    .clock(clock), .reset(reset), .ren_in(ren_in), .rd_in(rd_in), .data_write(data_write),
    .readA(readA), .readB(readB), .A(A), .B(B), .masterSwitch(masterSwitch),
    .frame_tick(frame_tick), .orient_valid(orient_valid), .orient_in(orient_in),
    .pwr_set(pwr_set), .pwr_set_data(pwr_set_data), .bike_pos(bike_pos),
    .bike_orient(bike_orient), .bike_pwr(bike_pwr), .frame_count(frame_count),
    .speed_out(speed_out)
  );

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] m_cur [NR];
  logic [DW-1:0] m_nx  [NR];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: what every register should hold after the coming edge.
  task automatic compute_next();
    bit cpu_wr;
    int o, p;
    m_nx = m_cur;
    if (!reset) begin
      foreach (m_nx[k]) m_nx[k] = '0;
      return;
    end
    cpu_wr = ren_in && (rd_in != '0);
    if (cpu_wr) m_nx[rd_in] = data_write;
    if (!(ren_in && int'(rd_in) == FR) && frame_tick && masterSwitch)
      m_nx[FR] = m_cur[FR] + 32'd1;
    for (int b = 0; b < NB; b++) begin
      o = BB + 2*b + 1;
      p = PB + b;
      if (orient_valid[b] && masterSwitch &&
          (orient_in[2*b +: 2] != (m_cur[o][1:0] ^ 2'b10)))
        m_nx[o] = {30'b0, orient_in[2*b +: 2]};
      if (pwr_set[b])
        m_nx[p] = pwr_set_data[32*b +: 32];
      else if (!(ren_in && int'(rd_in) == p) && frame_tick && masterSwitch && m_cur[p] != 0)
        m_nx[p] = m_cur[p] - 32'd1;
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    logic [DW*NB-1:0] e_pos, e_or, e_pw;
    #1;
    compute_next();
    check("readA", A, m_nx[readA]);
    check("readB", B, m_nx[readB]);
    @(posedge clock);
    m_cur = m_nx;
    #1;
    for (int b = 0; b < NB; b++) begin
      e_pos[b*DW +: DW] = m_cur[BB + 2*b];
      e_or[b*DW +: DW]  = m_cur[BB + 2*b + 1];
      e_pw[b*DW +: DW]  = m_cur[PB + b];
    end
    check("bike_pos", bike_pos, e_pos);
    check("bike_orient", bike_orient, e_or);
    check("bike_pwr", bike_pwr, e_pw);
    check("frame_count", frame_count, m_cur[FR]);
    check("speed_out", speed_out, m_cur[SR]);
    @(negedge clock);
  endtask

  initial begin
    logic [DW-1:0] pexp [4];
    pexp = '{32'd2, 32'd1, 32'd0, 32'd0};

    reset = 1'b0; ren_in = 1'b0; rd_in = '0; data_write = '0;
    readA = '0; readB = '0; masterSwitch = 1'b0; frame_tick = 1'b0;
    orient_valid = '0; orient_in = '0; pwr_set = '0; pwr_set_data = '0;
    foreach (m_cur[k]) m_cur[k] = '0;
    @(negedge clock);
    step();
    step();
    reset = 1'b1;

    // Preload every register, then reset and sweep all addresses.
    ren_in = 1'b1;
    for (int k = 1; k < NR; k++) begin
      rd_in = AW'(k);
      data_write = $urandom;
      readA = AW'(k);
      readB = AW'(NR - k);
      step();
    end
    ren_in = 1'b0;
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("rst_frame", frame_count, 32'd0);
    check("rst_pos", bike_pos, 128'd0);
    for (int k = 0; k < NR; k++) begin
      readA = AW'(k);
      readB = AW'(NR - 1 - k);
      step();
      check("rst_readA", A, 32'd0);
    end

    // r0 is never written; same-cycle writes forward to the read port.
    ren_in = 1'b1; rd_in = 5'd0; data_write = 32'hFFFF; readA = 5'd0;
    #1 check("r0_read", A, 32'd0);
    step();
    rd_in = 5'd5; data_write = 32'h1234; readA = 5'd5;
    #1 check("fwd_A", A, 32'h1234);
    step();

    // Turns on bike1: reversal dropped, valid turn accepted, frozen when stopped.
    masterSwitch = 1'b1; rd_in = 5'd19; data_write = 32'd1; readA = 5'd19;
    step();
    ren_in = 1'b0; orient_valid = 4'b0010; orient_in = 8'h0C;
    step();
    check("turn_reverse", bike_orient[63:32], 32'd1);
    orient_in = 8'h00;
    step();
    check("turn_up", bike_orient[63:32], 32'd0);
    masterSwitch = 1'b0; orient_in = 8'h08;
    step();
    check("turn_stopped", bike_orient[63:32], 32'd0);
    orient_valid = '0;

    // Hardware turn beats a same-cycle CPU write to bike0 orientation.
    masterSwitch = 1'b1; ren_in = 1'b1; rd_in = 5'd17; data_write = 32'd2;
    orient_valid = 4'b0001; orient_in = 8'h01; readA = 5'd17;
    #1 check("coll_fwd", A, 32'd1);
    step();
    check("coll_store", bike_orient[31:0], 32'd1);
    ren_in = 1'b0; orient_valid = '0; orient_in = '0;

    // Powerup countdown on bike2, saturating at zero; a grant beats a tick.
    pwr_set = 4'b0100; pwr_set_data[95:64] = 32'd3; readA = 5'd26;
    step();
    check("pwr_load", bike_pwr[95:64], 32'd3);
    pwr_set = '0; frame_tick = 1'b1;
    for (int t = 0; t < 4; t++) begin
      step();
      check("pwr_tick", bike_pwr[95:64], pexp[t]);
    end
    pwr_set = 4'b0100;
    step();
    check("pwr_load_vs_tick", bike_pwr[95:64], 32'd3);
    pwr_set = '0; frame_tick = 1'b0;

    // Frame counter wrap, CPU priority, and hold while stopped.
    ren_in = 1'b1; rd_in = 5'd28; data_write = 32'hFFFF_FFFF; readA = 5'd28;
    step();
    ren_in = 1'b0; frame_tick = 1'b1;
    step();
    check("frame_wrap", frame_count, 32'd0);
    ren_in = 1'b1; data_write = 32'd7;
    step();
    check("frame_cpu_wins", frame_count, 32'd7);
    ren_in = 1'b0; masterSwitch = 1'b0;
    step();
    check("frame_stopped", frame_count, 32'd7);
    frame_tick = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 500; n++) begin
      reset        = ($urandom_range(39, 0) != 0);
      ren_in       = 1'($urandom_range(1, 0));
      rd_in        = AW'($urandom_range(31, 0));
      data_write   = ($urandom_range(3, 0) == 0) ? 32'($urandom_range(3, 0)) : $urandom;
      readA        = AW'($urandom_range(31, 0));
      readB        = ($urandom_range(1, 0) == 0) ? rd_in : AW'($urandom_range(31, 0));
      masterSwitch = ($urandom_range(4, 0) != 0);
      frame_tick   = 1'($urandom_range(1, 0));
      orient_valid = NB'($urandom);
      orient_in    = (2*NB)'($urandom);
      pwr_set      = NB'($urandom & $urandom & $urandom);
      for (int b = 0; b < NB; b++)
        pwr_set_data[b*DW +: DW] = 32'($urandom_range(5, 0));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
